// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial-link credit receiver: credit counter
// width helper and the on-link packet layout.
package serial_link_pkg;

    // Width of a counter that must hold 0..num_credits inclusive.
    function automatic int unsigned cred_width(input int unsigned num_credits);
        return $clog2(num_credits + 32'd1);
    endfunction

    localparam int unsigned DefaultNumCredits = 32'd8;

    typedef logic [cred_width(DefaultNumCredits)-1:0] link_credit_t;

    // Packet as delivered by the data-link layer.
    typedef struct packed {
        link_credit_t credits;
        logic         cred_only;
        logic         data;
    } link_pkt_t;

endpackage

// File: rtl/serial_link_credit_receiver_if.sv
// Link-side and sink-side handshake bundle of the credit receiver.
// slave: receiver view; master: driver of packets and consumer of the head.
interface serial_link_credit_receiver_if #(
    parameter type         data_t     = logic,
    parameter int unsigned NumCredits = 32'd8
);
    import serial_link_pkg::*;

    localparam int unsigned CredW = cred_width(NumCredits);

    logic             rcv_valid_i;
    data_t            rcv_data_i;
    logic [CredW-1:0] rcv_credits_i;
    logic             rcv_cred_only_i;
    data_t            data_o;
    logic             valid_o;
    logic             ready_i;

    modport slave (
        input  rcv_valid_i, rcv_data_i, rcv_credits_i, rcv_cred_only_i, ready_i,
        output data_o, valid_o
    );

    modport master (
        output rcv_valid_i, rcv_data_i, rcv_credits_i, rcv_cred_only_i, ready_i,
        input  data_o, valid_o
    );

endinterface

// File: rtl/serial_link_credit_rx_checker.sv
// Run-time checks for the credit receiver; only exists when
// SERIAL_LINK_CREDIT_RX_CHECK_EN is defined.
`ifdef SERIAL_LINK_CREDIT_RX_CHECK_EN
module serial_link_credit_rx_checker #(
    parameter int unsigned NumCredits = 32'd8,
    parameter int unsigned CredW      = 32'd4
) (
    input logic             clk_i,
    input logic             rst_ni,
    input logic             overflow_i,
    input logic             pop_i,
    input logic [CredW-1:0] fill_i
);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !overflow_i);
    a_fill_bound:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    fill_i <= CredW'(NumCredits));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     pop_i |-> (fill_i != '0));
endmodule
`endif

// File: rtl/serial_link_credit_rx_queue.sv
// Circular receive buffer: NumCredits entries, arbitrary (non power of two)
// depth, no fall-through. Flush clears first, then a same-cycle push lands.
// A push into a full queue without a simultaneous pop is dropped.
module serial_link_credit_rx_queue import serial_link_pkg::*; #(
    parameter type         data_t     = logic,
    parameter int unsigned NumCredits = 32'd8,
    parameter type         credit_t   = logic [cred_width(NumCredits)-1:0]
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    push_i,
    input  data_t   data_i,
    input  logic    pop_i,
    input  logic    flush_i,
    output data_t   data_o,
    output logic    valid_o,
    output credit_t fill_o,
    output logic    full_o
);
    localparam int unsigned PtrW = (NumCredits > 32'd1) ? $clog2(NumCredits) : 32'd1;
    typedef logic [PtrW-1:0] ptr_t;
    localparam ptr_t    LastIdx = ptr_t'(NumCredits - 32'd1);
    localparam credit_t Depth   = credit_t'(NumCredits);

    data_t   mem_q [NumCredits];
    data_t   mem_d [NumCredits];
    ptr_t    rd_ptr_q, rd_ptr_d;
    ptr_t    wr_ptr_q, wr_ptr_d;
    credit_t fill_q, fill_d;
    ptr_t    wr_base_s;
    logic    full_s, pop_s, push_s;

    function automatic ptr_t ptr_next(input ptr_t p);
        return (p == LastIdx) ? '0 : p + ptr_t'(1);
    endfunction

    // Next-state of storage, pointers and occupancy
    always_comb begin
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        full_s    = (fill_q == Depth);
        // A pop coinciding with flush is already covered by the flush
        pop_s     = pop_i & (fill_q != '0) & ~flush_i;
        push_s    = push_i & (flush_i | ~full_s | pop_s);
        wr_base_s = flush_i ? '0 : wr_ptr_q;
        if (push_s) begin
            mem_d[wr_base_s] = data_i;
            wr_ptr_d         = ptr_next(wr_base_s);
        end else begin
            wr_ptr_d         = wr_base_s;
        end
        if (flush_i) begin
            rd_ptr_d = '0;
            fill_d   = credit_t'(push_s);
        end else if (pop_s) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
            fill_d   = fill_q + credit_t'(push_s) - credit_t'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
            fill_d   = fill_q + credit_t'(push_s);
        end
    end

    // Queue state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (fill_q != '0);
    assign fill_o  = fill_q;
    assign full_o  = full_s;

endmodule

// File: rtl/serial_link_credit_receiver.sv
// Receive side of the credit-based serial link. Strips the piggy-backed
// credit field (registered, one-cycle pulse), buffers payloads and reports
// released entries for credit return.
// Optional: SERIAL_LINK_CREDIT_RX_CHECK_EN enables the sticky overflow flag
// and the run-time checker.
module serial_link_credit_receiver import serial_link_pkg::*; #(
    parameter type         data_t     = logic,
    parameter int unsigned NumCredits = 32'd8,
    parameter type         credit_t   = logic [cred_width(NumCredits)-1:0]
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    serial_link_credit_receiver_if.slave link,
    input  logic    flush_i,
    output credit_t credits_received_o,
    output logic    receive_cred_o,
    output credit_t credits_released_o,
    output credit_t fill_o,
    output logic    overflow_o
);
    logic    push_s, pop_s, full_s;
    credit_t fill_s;
    logic    rc_valid_q, rc_valid_d;
    credit_t rc_credits_q, rc_credits_d;

    assign push_s = link.rcv_valid_i & ~link.rcv_cred_only_i;
    assign pop_s  = link.valid_o & link.ready_i;

    serial_link_credit_rx_queue #(
        .data_t     (data_t),
        .NumCredits (NumCredits),
        .credit_t   (credit_t)
    ) u_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_s),
        .data_i  (link.rcv_data_i),
        .pop_i   (pop_s),
        .flush_i (flush_i),
        .data_o  (link.data_o),
        .valid_o (link.valid_o),
        .fill_o  (fill_s),
        .full_o  (full_s)
    );

    // Capture the credit field of any valid packet carrying non-zero credits
    always_comb begin
        rc_valid_d   = 1'b0;
        rc_credits_d = '0;
        if (link.rcv_valid_i && (link.rcv_credits_i != '0)) begin
            rc_valid_d   = 1'b1;
            rc_credits_d = link.rcv_credits_i;
        end else begin
            rc_valid_d   = 1'b0;
            rc_credits_d = '0;
        end
    end

    // Registered credit extraction
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rc_valid_q   <= 1'b0;
            rc_credits_q <= '0;
        end else begin
            rc_valid_q   <= rc_valid_d;
            rc_credits_q <= rc_credits_d;
        end
    end

    // Entries freed this cycle: whole occupancy on flush, else one per pop
    always_comb begin
        credits_released_o = '0;
        if (flush_i) begin
            credits_released_o = fill_s;
        end else if (pop_s) begin
            credits_released_o = credit_t'(1'b1);
        end else begin
            credits_released_o = '0;
        end
    end

    assign receive_cred_o     = rc_valid_q;
    assign credits_received_o = rc_credits_q;
    assign fill_o             = fill_s;

`ifdef SERIAL_LINK_CREDIT_RX_CHECK_EN
    logic overflow_s;
    logic overflow_q, overflow_d;

    // Push into a full queue with nothing leaving is dropped
    always_comb begin
        overflow_s = push_s & full_s & ~pop_s & ~flush_i;
        overflow_d = overflow_q | overflow_s;
    end

    // Sticky overflow flag, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow_o = overflow_q;

    serial_link_credit_rx_checker #(
        .NumCredits (NumCredits),
        .CredW      ($bits(credit_t))
    ) u_checker (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .overflow_i (overflow_s),
        .pop_i      (pop_s),
        .fill_i     (fill_s)
    );
`else
    logic unused_full_s;
    assign unused_full_s = full_s;
    assign overflow_o    = 1'b0;
`endif

endmodule

// File: doc/serial_link_credit_receiver.md
Name: serial_link_credit_receiver

Overview:
- Receive-side counterpart of the link's credit-based flow control.
- Accepts packets from the physical/data-link layer without backpressure. The transmitter's credit accounting guarantees free space.
- Strips the piggy-backed credit field and forwards it, registered, to the local credit-synchronization unit.
- Buffers valid payloads in a NumCredits-deep queue and reports every released entry so credits can be returned to the remote side.

Parameters:
- data_t, logic, payload type.
- NumCredits, 8, queue depth. Equals the remote side's initial credit count. Must be >= 2.
- credit_t, logic [$clog2(NumCredits+1)-1:0], credit counter type. Must hold 0..NumCredits.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- rcv_valid_i  in  1  incoming packet valid. No ready; the packet is accepted unconditionally.
- rcv_data_i  in  $bits(data_t)  incoming payload
- rcv_credits_i  in  credit_t  credits carried by the packet
- rcv_cred_only_i  in  1  packet carries credits only, no payload
- data_o  out  $bits(data_t)  queue head
- valid_o  out  1  queue non-empty
- ready_i  in  1  sink accepts head
- flush_i  in  1  synchronous clear of the queue
- credits_received_o  out  credit_t  credits extracted from the last packet
- receive_cred_o  out  1  credits_received_o is valid (one-cycle pulse)
- credits_released_o  out  credit_t  entries freed this cycle
- fill_o  out  credit_t  current occupancy
- overflow_o  out  1  sticky overflow flag

Behaviour:
- Reset values:
  - all pointers and counters = 0
  - valid_o = 0, data_o = 0
  - receive_cred_o = 0, credits_received_o = 0
  - credits_released_o = 0, fill_o = 0, overflow_o = 0
- Push condition: rcv_valid_i & ~rcv_cred_only_i.
- Pop condition: valid_o & ready_i.
- Queue: circular buffer with read and write pointers.
  - Pointers wrap from NumCredits-1 to 0; NumCredits need not be a power of two.
  - No fall-through. A pushed entry appears on data_o/valid_o at the earliest one cycle after the push.
  - data_o is the head register; it holds its value while valid_o & ~ready_i.
- Credit extraction: for every rcv_valid_i (payload or credit-only) with rcv_credits_i != 0, in the next cycle:
  - receive_cred_o = 1
  - credits_received_o = rcv_credits_i
  - Otherwise both are 0. Registered latency is exactly 1 cycle.
- credits_released_o is combinational from the current cycle: 1 on pop, 0 otherwise, except during flush.
- Flush:
  - On flush_i, credits_released_o = fill_o (the current occupancy). Next cycle fill = 0 and the queue is empty.
  - A pop in the same cycle as flush_i is ignored; the flush count already includes it.
  - A push in the same cycle as flush_i is written after the clear, so next fill = 1.
- Full queue (fill == NumCredits):
  - Push with simultaneous pop: legal, fill unchanged.
  - Push without pop: overflow. The payload is dropped and the pointers are unchanged. The credit field is still extracted.
- Empty queue with push: fill = 1 next cycle. A pop is not possible in the push cycle.
- Credit-only packets never touch the queue or fill_o.
- fill_d = fill_q + push_accepted - pop, or = push_accepted on flush.

Optional Feature:
- Macro: SERIAL_LINK_CREDIT_RX_CHECK_EN.
- Defined:
  - Overflow sets overflow_o, which stays 1 until reset. flush_i does not clear it.
  - Assertions are enabled: no overflow, fill_o <= NumCredits, no pop when empty.
- Undefined:
  - overflow_o is tied to 0 and no assertions are compiled.
  - An overflowing push is still silently dropped.

Decomposition:
- serial_link_pkg holds:
  - the credit_t width helper function (clog2(NumCredits+1))
  - the packet struct {credits, cred_only, data} used on the link
- Natural sub-module: serial_link_credit_rx_queue. It is the circular buffer with push, pop, flush, fill and full outputs, non-power-of-two wrap, and no fall-through.
- The top level adds credit extraction, the release count and overflow handling.

Test Plan (NumCredits=8):
- Push payloads A and B back-to-back with ready_i=0 -> valid_o rises 1 cycle after the A push; data_o=A; fill_o=2; credits_released_o=0.
- Credit-only packet with rcv_credits_i=5 -> next cycle receive_cred_o=1 and credits_received_o=5 for exactly one cycle; fill_o unchanged.
- Fill to 8, then push + pop in the same cycle for 20 cycles -> fill_o stays 8, FIFO order is preserved, credits_released_o=1 each cycle, overflow_o=0.
- With fill=8, push without pop (CHECK_EN) -> payload dropped, fill_o=8, overflow_o=1 and sticky. A credit field of 3 in that packet still yields credits_received_o=3.
- fill=5, flush_i together with a push of C -> credits_released_o=5 that cycle; next cycle fill_o=1; data_o=C one cycle later.
- Random pushes bounded by a credit model, with wrap past pointer index 7 repeated 100 times -> scoreboard order matches; sum of credits_released_o equals number of pushes; fill_o returns to 0.
